i2c_txn_scheduler: RTL and testbench
====================================

// Module: i2c_txn_scheduler
// PURPOSE
//  Shares one byte-level I2C master among NUM_REQ on-chip requesters (LED, FND, switch pollers).
//  Round-robin arbitration; each granted request runs as one single-byte transaction:
//  START, addr byte, one data byte (write or read), STOP.
//  Retries on NACK, guards every master command with a watchdog, returns a status per request.
// PARAMETERS
//  NUM_REQ      3       number of requesters, 2..8
//  MAX_RETRY    2       extra attempts after a NACK (0 = no retry)
//  TIMEOUT_CYC  200000  clk cycles allowed per master command before abort (2 ms @ 100 MHz)
// PORTS
//  clk          in   1           100 MHz system clock; the only clock
//  rst_n        in   1           asynchronous, active-low reset
//  req_valid    in   NUM_REQ     per-requester level request; held until its rsp_done pulse
//  req_addr     in   7*NUM_REQ   7-bit slave address, requester i in [7i+6:7i]
//  req_rw       in   NUM_REQ     1 = read, 0 = write
//  req_wdata    in   8*NUM_REQ   write byte, requester i in [8i+7:8i]
//  rsp_done     out  NUM_REQ     one-hot 1-cycle completion pulse
//  rsp_err      out  1           valid with rsp_done: 1 = failed
//  rsp_code     out  2           00 OK, 01 NACK_ADDR, 10 NACK_DATA, 11 TIMEOUT
//  rsp_rdata    out  8           read byte, valid with rsp_done when req_rw = 1 and OK
//  m_cmd_valid  out  1           command to master
//  m_cmd_ready  in   1           master accepts command
//  m_cmd        out  2           00 START, 01 WRITE, 10 READ_NACK, 11 STOP
//  m_wdata      out  8           byte for WRITE
//  m_done       in   1           1-cycle pulse: accepted command finished on the bus
//  m_nack       in   1           valid with m_done after WRITE: 1 = slave did not ACK
//  m_rdata      in   8           valid with m_done after READ_NACK
//  busy         out  1           1 when not in IDLE
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, all outputs 0 (m_cmd 00, m_wdata 00, rsp_rdata 00).
//  FSM: IDLE > GRANT > START > ADDR > DATA > STOP > RESP > IDLE.
//  - IDLE: if any req_valid, go GRANT next cycle.
//  - GRANT: pick the first set req_valid at or after the rr pointer (wrapping).
//    Latch its addr/rw/wdata; retry_cnt = 0; pointer = winner+1 mod NUM_REQ.
//  - Each command state asserts m_cmd_valid with stable m_cmd/m_wdata until the cycle m_cmd_ready=1.
//    It then deasserts and waits for m_done. A new command is never issued before the prior m_done.
//  - ADDR: m_cmd WRITE, m_wdata = {addr,rw}; for 0x55 write the byte is 0xAA.
//    m_nack=1: if retry_cnt < MAX_RETRY, go to STOP and then START again with retry_cnt+1.
//    Otherwise record code NACK_ADDR and go STOP.
//  - DATA: write issues WRITE wdata; NACK is handled as in ADDR with code NACK_DATA.
//    Read issues READ_NACK and latches m_rdata at m_done.
//  - STOP always precedes RESP, so the bus is never left held.
//  - RESP: one-cycle rsp_done[winner] with err/code/rdata, then IDLE.
//    A requester whose req_valid is still high after rsp_done is treated as a new request.
//  - Watchdog: counter clears at each command issue and counts while waiting for ready or done.
//    At TIMEOUT_CYC: code TIMEOUT, no retry, go STOP.
//    A timeout in STOP itself goes straight to RESP.
//  - req_valid dropping mid-transaction is ignored; the transaction completes and responds.
//  - Stray m_done with no command outstanding is ignored.
//  - Async reset mid-transaction aborts immediately with no rsp_done. The master shares rst_n.
//  - Latency with an ideal master (ready=1, done next cycle): write or read, rsp_done 10 cycles after req_valid.
// STRUCTURE
//  i2c_pkg: i2c_cmd_t enum (START/WRITE/READ_NACK/STOP), rsp_code_t enum, sched_state_t enum.
//  Sub-module rr_arbiter #(N): req vector + advance strobe -> one-hot grant, internal pointer.
//  Scheduler FSM, watchdog and retry counter live in the top.
// TESTING (behavioural master model with programmable ready delay, NACK and hang)
//  1 req0 write 0x55/0xA5 -> cmds START, WRITE 0xAA, WRITE 0xA5, STOP; rsp_done[0], code 00
//  2 req1 read 0x56, model returns 0x3C -> WRITE 0xAD, READ_NACK; rsp_rdata 0x3C, code 00
//  3 addr NACK every attempt, MAX_RETRY=2 -> 3 START/ADDR/STOP sequences; err=1, code 01
//  4 req0..2 all valid, held -> done order 0,1,2,0; req2 alone after winner 2 -> served next
//  5 m_done withheld after DATA -> TIMEOUT_CYC later STOP issued; err=1, code 11; busy drops
//  6 rst_n low during DATA wait -> all outputs 0, IDLE, no rsp_done; next request completes OK

Source files
------------

// File: rtl/i2c_txn_scheduler_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | i2c_txn_scheduler_pkg                                             |
// | Shared types and command helpers for the I2C transaction scheduler|
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package i2c_txn_scheduler_pkg;

  typedef enum logic [1:0] {
    CMD_START     = 2'b00,
    CMD_WRITE     = 2'b01,
    CMD_READ_NACK = 2'b10,
    CMD_STOP      = 2'b11
  } i2c_cmd_t;

  typedef enum logic [1:0] {
    RSP_OK        = 2'b00,
    RSP_NACK_ADDR = 2'b01,
    RSP_NACK_DATA = 2'b10,
    RSP_TIMEOUT   = 2'b11
  } rsp_code_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_START = 3'd2,
    ST_ADDR  = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5,
    ST_RESP  = 3'd6
  } sched_state_t;

  function automatic logic is_cmd_state(sched_state_t st);
    return (st == ST_START) || (st == ST_ADDR) || (st == ST_DATA) || (st == ST_STOP);
  endfunction

  function automatic i2c_cmd_t cmd_for_state(sched_state_t st, logic rw);
    case (st)
      ST_ADDR: return CMD_WRITE;
      ST_DATA: return rw ? CMD_READ_NACK : CMD_WRITE;
      ST_STOP: return CMD_STOP;
      default: return CMD_START;
    endcase
  endfunction

  function automatic logic [7:0] wdata_for_state(sched_state_t st, logic [6:0] addr,
                                                 logic rw, logic [7:0] wdata);
    case (st)
      ST_ADDR: return {addr, rw};
      ST_DATA: return rw ? 8'h00 : wdata;
      default: return 8'h00;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_txn_scheduler_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter                                                        |
// | Round-robin one-hot arbiter; pointer moves past winner on advance |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int c_IW = $clog2(N);

  logic [c_IW-1:0] r_ptr;
  logic [c_IW-1:0] w_idx;
  logic [c_IW-1:0] w_k;
  logic [N-1:0]    w_grant;
  logic            w_found;

  // Scan from the pointer, wrapping, and take the first active request.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_k     = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_k = c_IW'((int'(r_ptr) + i) % N);
      if (!w_found && req[w_k]) begin
        w_found      = 1'b1;
        w_idx        = w_k;
        w_grant[w_k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (advance && w_found) begin
      r_ptr <= (int'(w_idx) == N - 1) ? '0 : w_idx + 1'b1;
    end
  end

  assign grant     = w_grant;
  assign grant_idx = w_idx;

endmodule
`default_nettype wire

// File: rtl/i2c_txn_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | i2c_txn_scheduler                                                 |
// | Round-robin sharing of one byte-level I2C master, with retry,     |
// | per-command watchdog and per-request status.  Revision: 1.0       |
// +------------------------------------------------------------------+
module i2c_txn_scheduler
  import i2c_txn_scheduler_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int MAX_RETRY   = 2,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   rsp_done,
  output logic                 rsp_err,
  output logic [1:0]           rsp_code,
  output logic [7:0]           rsp_rdata,
  output logic                 m_cmd_valid,
  input  logic                 m_cmd_ready,
  output logic [1:0]           m_cmd,
  output logic [7:0]           m_wdata,
  input  logic                 m_done,
  input  logic                 m_nack,
  input  logic [7:0]           m_rdata,
  output logic                 busy
);

  localparam int c_IW  = $clog2(NUM_REQ);
  localparam int c_RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int c_WDW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_WDW-1:0]   c_WD_LAST = c_WDW'(TIMEOUT_CYC - 1);
  localparam logic [NUM_REQ-1:0] c_ONE     = NUM_REQ'(1);

  sched_state_t       r_state, w_nxt;
  logic [NUM_REQ-1:0] w_grant;
  logic [c_IW-1:0]    w_gidx, r_idx;
  logic [6:0]         w_addr_arr  [NUM_REQ];
  logic [7:0]         w_wdata_arr [NUM_REQ];

  logic [6:0]         r_addr;
  logic               r_rw;
  logic [7:0]         r_wdata, r_rdata;
  logic [c_RW-1:0]    r_retry;
  logic               r_restart;
  rsp_code_t          r_code;

  logic               r_cmd_valid, r_wait;
  i2c_cmd_t           r_cmd;
  logic [7:0]         r_cmd_wdata;
  logic [c_WDW-1:0]   r_wd;

  logic [NUM_REQ-1:0] r_rsp_done;
  logic               r_rsp_err;
  rsp_code_t          r_rsp_code;
  logic [7:0]         r_rsp_rdata;

  logic      w_in_cmd, w_accept, w_done, w_timeout, w_nack, w_can_retry, w_enter_resp;
  rsp_code_t w_resp_code;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr_arr[gi]  = req_addr[7*gi +: 7];
      assign w_wdata_arr[gi] = req_wdata[8*gi +: 8];
    end
  endgenerate

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .advance   (r_state == ST_GRANT),
    .grant     (w_grant),
    .grant_idx (w_gidx)
  );

  assign w_in_cmd    = is_cmd_state(r_state);
  assign w_accept    = r_cmd_valid & m_cmd_ready;
  assign w_done      = r_wait & m_done;
  // Watchdog spans issue through done; accept alone does not restart it.
  assign w_timeout   = w_in_cmd & (r_wd == c_WD_LAST) &
                       ((r_cmd_valid & ~m_cmd_ready) | (r_wait & ~m_done));
  assign w_nack      = w_done & m_nack &
                       ((r_state == ST_ADDR) | ((r_state == ST_DATA) & ~r_rw));
  assign w_can_retry = int'(r_retry) < MAX_RETRY;
  assign w_resp_code = w_timeout ? RSP_TIMEOUT : r_code;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (|req_valid) w_nxt = ST_GRANT;
      ST_GRANT: w_nxt = (|w_grant) ? ST_START : ST_IDLE;
      ST_START: begin
        if (w_timeout)   w_nxt = ST_STOP;
        else if (w_done) w_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        if (w_timeout || (w_done && m_nack)) w_nxt = ST_STOP;
        else if (w_done)                     w_nxt = ST_DATA;
      end
      ST_DATA:  if (w_timeout || w_done) w_nxt = ST_STOP;
      ST_STOP: begin
        if (w_timeout)   w_nxt = ST_RESP;
        else if (w_done) w_nxt = r_restart ? ST_START : ST_RESP;
      end
      ST_RESP:  w_nxt = ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
  end

  assign w_enter_resp = (w_nxt == ST_RESP) && (r_state != ST_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_addr      <= '0;
      r_rw        <= 1'b0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_retry     <= '0;
      r_restart   <= 1'b0;
      r_code      <= RSP_OK;
      r_cmd_valid <= 1'b0;
      r_wait      <= 1'b0;
      r_cmd       <= CMD_START;
      r_cmd_wdata <= '0;
      r_wd        <= '0;
      r_rsp_done  <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_code  <= RSP_OK;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_nxt;
      r_rsp_done  <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_code  <= RSP_OK;
      r_rsp_rdata <= '0;

      if (w_in_cmd) r_wd <= r_wd + 1'b1;
      if (w_accept) begin
        r_cmd_valid <= 1'b0;
        r_wait      <= 1'b1;
      end
      if (w_done || w_timeout) begin
        r_cmd_valid <= 1'b0;
        r_wait      <= 1'b0;
      end

      if (r_state == ST_GRANT && |w_grant) begin
        r_idx     <= w_gidx;
        r_addr    <= w_addr_arr[w_gidx];
        r_rw      <= req_rw[w_gidx];
        r_wdata   <= w_wdata_arr[w_gidx];
        r_rdata   <= '0;
        r_retry   <= '0;
        r_restart <= 1'b0;
        r_code    <= RSP_OK;
      end

      if (w_nack) begin
        if (w_can_retry) begin
          r_retry   <= r_retry + 1'b1;
          r_restart <= 1'b1;
        end else begin
          r_code <= (r_state == ST_ADDR) ? RSP_NACK_ADDR : RSP_NACK_DATA;
        end
      end
      if (w_timeout) begin
        r_code    <= RSP_TIMEOUT;
        r_restart <= 1'b0;
      end
      if (r_state == ST_DATA && w_done && r_rw) r_rdata <= m_rdata;

      // Entering any command state issues that state's command.
      if (w_nxt != r_state && is_cmd_state(w_nxt)) begin
        r_cmd_valid <= 1'b1;
        r_cmd       <= cmd_for_state(w_nxt, r_rw);
        r_cmd_wdata <= wdata_for_state(w_nxt, r_addr, r_rw, r_wdata);
        r_wait      <= 1'b0;
        r_wd        <= '0;
        if (w_nxt == ST_START) r_restart <= 1'b0;
      end

      if (w_enter_resp) begin
        r_rsp_done  <= c_ONE << r_idx;
        r_rsp_err   <= (w_resp_code != RSP_OK);
        r_rsp_code  <= w_resp_code;
        r_rsp_rdata <= (r_rw && w_resp_code == RSP_OK) ? r_rdata : 8'h00;
      end
    end
  end

  assign m_cmd_valid = r_cmd_valid;
  assign m_cmd       = r_cmd;
  assign m_wdata     = r_cmd_wdata;
  assign rsp_done    = r_rsp_done;
  assign rsp_err     = r_rsp_err;
  assign rsp_code    = r_rsp_code;
  assign rsp_rdata   = r_rsp_rdata;
  assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_i2c_txn_scheduler                                              |
// | Directed bench with a behavioural byte-level I2C master model.    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_i2c_txn_scheduler;

  localparam int NREQ = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NREQ-1:0]  req_valid;
  logic [7*NREQ-1:0] req_addr;
  logic [NREQ-1:0]  req_rw;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]  rsp_done;
  logic             rsp_err;
  logic [1:0]       rsp_code;
  logic [7:0]       rsp_rdata;
  logic             m_cmd_valid, m_cmd_ready;
  logic [1:0]       m_cmd;
  logic [7:0]       m_wdata;
  logic             m_done, m_nack;
  logic [7:0]       m_rdata;
  logic             busy;

  i2c_txn_scheduler #(.NUM_REQ(NREQ), .MAX_RETRY(2), .TIMEOUT_CYC(40)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_rw(req_rw), .req_wdata(req_wdata), .rsp_done(rsp_done), .rsp_err(rsp_err),
    .rsp_code(rsp_code), .rsp_rdata(rsp_rdata), .m_cmd_valid(m_cmd_valid),
    .m_cmd_ready(m_cmd_ready), .m_cmd(m_cmd), .m_wdata(m_wdata), .m_done(m_done),
    .m_nack(m_nack), .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Master model knobs and command log ({cmd, wdata} per accepted command).
  int         ready_delay = 0;
  int         vcnt;
  logic       nack_addr_mode = 1'b0;
  logic       hang_data = 1'b0;
  logic [7:0] rd_val = 8'h00;
  logic       prev_start;
  logic [9:0] log_q[$];

  assign m_cmd_ready = m_cmd_valid && (vcnt >= ready_delay);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_done <= 1'b0; m_nack <= 1'b0; m_rdata <= 8'h00; vcnt <= 0; prev_start <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_nack <= 1'b0;
      vcnt   <= (m_cmd_valid && !m_cmd_ready) ? vcnt + 1 : 0;
      if (m_cmd_valid && m_cmd_ready) begin
        log_q.push_back({m_cmd, m_wdata});
        prev_start <= (m_cmd == 2'b00);
        if (!(hang_data && m_cmd == 2'b01 && !prev_start)) begin
          m_done  <= 1'b1;
          m_nack  <= nack_addr_mode && m_cmd == 2'b01 && prev_start;
          m_rdata <= (m_cmd == 2'b10) ? rd_val : 8'h00;
        end
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd);
    req_addr[7*i +: 7]  = a;
    req_rw[i]           = rw;
    req_wdata[8*i +: 8] = wd;
  endtask

  logic       cap_err;
  logic [1:0] cap_code;
  logic [7:0] cap_rdata;

  task automatic wait_rsp(output logic [NREQ-1:0] dv, output int cyc);
    dv  = '0;
    cyc = 0;
    while (dv == '0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      dv = rsp_done;
      if (dv != '0) begin
        cap_err = rsp_err; cap_code = rsp_code; cap_rdata = rsp_rdata;
      end
    end
    check("rsp_seen", {31'd0, dv != '0}, 32'd1);
  endtask

  task automatic check_log(input string tag, input int idx, input logic [9:0] exp);
    logic [9:0] v;
    v = (idx < log_q.size()) ? log_q[idx] : 10'h3FF;
    check(tag, {22'd0, v}, {22'd0, exp});
  endtask

  logic [NREQ-1:0] dv;
  int              cyc;
  int              order [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_rw = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_valid", {31'd0, m_cmd_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_done", {29'd0, rsp_done}, 32'd0);
    check("rst_m_cmd_wdata", {22'd0, m_cmd, m_wdata}, 32'd0);
    check("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: req0 write addr 0x55 data 0xA5, ideal master
    log_q.delete();
    set_req(0, 7'h55, 1'b0, 8'hA5);
    req_valid[0] = 1'b1;
    wait_rsp(dv, cyc);
    req_valid[0] = 1'b0;
    check("t1_done", {29'd0, dv}, 32'h1);
    check("t1_latency", cyc, 32'd10);
    check("t1_err_code", {29'd0, cap_err, cap_code}, 32'h0);
    check("t1_nlog", log_q.size(), 32'd4);
    check_log("t1_c0", 0, {2'b00, 8'h00});
    check_log("t1_c1", 1, {2'b01, 8'hAA});
    check_log("t1_c2", 2, {2'b01, 8'hA5});
    check_log("t1_c3", 3, {2'b11, 8'h00});
    @(negedge clk);
    check("t1_busy_after", {31'd0, busy}, 32'd0);

    // 2: req1 read addr 0x56, model returns 0x3C, slow ready
    log_q.delete();
    ready_delay = 3; rd_val = 8'h3C;
    set_req(1, 7'h56, 1'b1, 8'h00);
    req_valid[1] = 1'b1;
    wait_rsp(dv, cyc);
    req_valid[1] = 1'b0;
    check("t2_done", {29'd0, dv}, 32'h2);
    check("t2_err_code", {29'd0, cap_err, cap_code}, 32'h0);
    check("t2_rdata", {24'd0, cap_rdata}, 32'h3C);
    check("t2_nlog", log_q.size(), 32'd4);
    check_log("t2_c1", 1, {2'b01, 8'hAD});
    check_log("t2_c2", 2, {2'b10, 8'h00});
    check_log("t2_c3", 3, {2'b11, 8'h00});
    ready_delay = 0;
    @(negedge clk);

    // 3: address NACK on every attempt, two retries
    log_q.delete();
    nack_addr_mode = 1'b1;
    set_req(2, 7'h20, 1'b0, 8'h11);
    req_valid[2] = 1'b1;
    wait_rsp(dv, cyc);
    req_valid[2] = 1'b0;
    nack_addr_mode = 1'b0;
    check("t3_done", {29'd0, dv}, 32'h4);
    check("t3_err_code", {29'd0, cap_err, cap_code}, 32'h5);
    check("t3_nlog", log_q.size(), 32'd9);
    for (int s = 0; s < 3; s++) begin
      check_log("t3_start", 3*s,     {2'b00, 8'h00});
      check_log("t3_addr",  3*s + 1, {2'b01, 8'h40});
      check_log("t3_stop",  3*s + 2, {2'b11, 8'h00});
    end
    @(negedge clk);

    // 4: all three held -> round-robin order, then req2 alone after winner 2
    set_req(0, 7'h01, 1'b0, 8'h10);
    set_req(1, 7'h02, 1'b0, 8'h20);
    set_req(2, 7'h03, 1'b0, 8'h30);
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_rsp(dv, cyc);
      check("t4_order", {29'd0, dv}, 32'd1 << order[k]);
    end
    req_valid = 3'b100;
    wait_rsp(dv, cyc);
    req_valid = '0;
    check("t4_req2_alone", {29'd0, dv}, 32'h4);
    @(negedge clk);

    // 5: done withheld after data write -> timeout, STOP, code 11
    log_q.delete();
    hang_data = 1'b1;
    set_req(0, 7'h10, 1'b0, 8'h77);
    req_valid[0] = 1'b1;
    wait_rsp(dv, cyc);
    req_valid[0] = 1'b0;
    hang_data = 1'b0;
    check("t5_done", {29'd0, dv}, 32'h1);
    check("t5_err_code", {29'd0, cap_err, cap_code}, 32'h7);
    check("t5_nlog", log_q.size(), 32'd4);
    check_log("t5_c2", 2, {2'b01, 8'h77});
    check_log("t5_c3", 3, {2'b11, 8'h00});
    @(negedge clk);
    check("t5_busy_drop", {31'd0, busy}, 32'd0);

    // 6: reset while waiting for data done
    log_q.delete();
    hang_data = 1'b1;
    set_req(1, 7'h33, 1'b0, 8'h44);
    req_valid[1] = 1'b1;
    cyc = 0;
    while (log_q.size() < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_reached_data", {31'd0, log_q.size() >= 3}, 32'd1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_outs", {18'd0, m_cmd_valid, m_cmd, m_wdata, busy},
          32'd0);
    check("t6_rst_rsp", {18'd0, rsp_done, rsp_err, rsp_code, rsp_rdata}, 32'd0);
    req_valid = '0;
    hang_data = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_rst_no_done", {29'd0, rsp_done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_idle_after_rst", {28'd0, busy, rsp_done}, 32'd0);
    log_q.delete();
    rd_val = 8'h9E;
    set_req(0, 7'h12, 1'b1, 8'h00);
    req_valid[0] = 1'b1;
    wait_rsp(dv, cyc);
    req_valid[0] = 1'b0;
    check("t6_next_done", {29'd0, dv}, 32'h1);
    check("t6_next_latency", cyc, 32'd10);
    check("t6_next_code", {29'd0, cap_err, cap_code}, 32'h0);
    check("t6_next_rdata", {24'd0, cap_rdata}, 32'h9E);
    check_log("t6_next_addr", 1, {2'b01, 8'h25});
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
